fht_frame_sched: RTL

FHT_FRAME_SCHED -- requirements
Module: fht_frame_sched

---
 rtl/fht_pkg.sv | 23 ++
 rtl/fht_skid_fifo.sv | 52 +++++
 rtl/fht_frame_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fht_pkg.sv
// Shared types and constants for the FHT frame scheduler and its sub-blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fht_pkg;

   // Defaults track fht_defines so the scheduler and core agree on geometry.
   localparam int FHT_A_BIT = 8;
   localparam int FHT_D_BIT = 16;

   // Core must drop its ready within this many cycles of the start pulse
   // (counted from the KICK cycle); otherwise the frame is abandoned.
   localparam int C_TMO_CYC = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_WAIT_LO,
      S_WAIT_HI,
      S_UNLOAD
   } sched_state_t;

endpackage

// File: rtl/fht_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle bank read latency on unload.
// Latency: a push is visible on o_rd_vld/o_rd_dat the following cycle.
// Backpressure: head held stable while i_rd_rdy is low; o_cnt lets the writer throttle.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_wr_vld/i_wr_dat push;
//        o_rd_vld/o_rd_dat/i_rd_rdy pop handshake; o_cnt current occupancy.
module fht_skid_fifo #(
   parameter int W = 17
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_wr_vld,
   input  logic [W-1:0] i_wr_dat,
   output logic         o_rd_vld,
   output logic [W-1:0] o_rd_dat,
   input  logic         i_rd_rdy,
   output logic [1:0]   o_cnt
);

   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign o_rd_vld = (r_cnt != 2'd0);
   assign o_rd_dat = r_mem[r_rp];
   assign o_cnt    = r_cnt;
   assign w_pop    = o_rd_vld & i_rd_rdy;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push   = i_wr_vld & ((r_cnt != 2'd2) | w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= i_wr_dat;
            r_wp        <= ~r_wp;
         end
         if (w_pop) begin
            r_rp <= ~r_rp;
         end
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/fht_frame_sched.sv
// Frame scheduler: loads N samples into 4 banks, kicks the FHT core, unloads results.
// Latency: core start the cycle after the last write; first result 2 cycles after banks return.
// Backpressure: input stalled outside IDLE/LOAD; unload reads throttled by a 2-entry output FIFO.
// Ports: iCLK/iRESET clock and async active-low reset; iIN_* / oIN_READY sample input;
//        oOUT_* / iOUT_READY result stream; oCORE_START/iCORE_RDY core handshake;
//        oBANK_OWN bank mux select; oIO_* / iIO_RDATA bank port; oBUSY/oFRAME_DONE/oERR status.
module fht_frame_sched
   import fht_pkg::*;
#(
   parameter int A_BIT = FHT_A_BIT,
   parameter int D_BIT = FHT_D_BIT
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iIN_VALID,
   input  logic [D_BIT-1:0] iIN_DATA,
   output logic             oIN_READY,
   output logic             oOUT_VALID,
   output logic [D_BIT-1:0] oOUT_DATA,
   output logic             oOUT_LAST,
   input  logic             iOUT_READY,
   output logic             oCORE_START,
   input  logic             iCORE_RDY,
   output logic             oBANK_OWN,
   output logic [1:0]       oIO_BANK,
   output logic [A_BIT-1:0] oIO_ADDR,
   output logic             oIO_WE,
   output logic [D_BIT-1:0] oIO_WDATA,
   input  logic [D_BIT-1:0] iIO_RDATA,
   output logic             oBUSY,
   output logic             oFRAME_DONE,
   output logic             oERR
);

   localparam int               K_BIT      = A_BIT + 2;
   localparam logic [K_BIT-1:0] K_LAST     = '1;
   localparam logic [2:0]       C_TMO_LAST = 3'(C_TMO_CYC - 1);

   sched_state_t     r_state;
   logic [K_BIT-1:0] r_k;
   logic [2:0]       r_tmo;
   logic             r_in_rdy;
   logic             r_bank_own;
   logic             r_start;
   logic             r_err;
   logic             r_done;
   logic             r_rd_pend;
   logic             r_rd_pend_last;
   logic             r_rd_all;

   logic             w_we;
   logic             w_issue;
   logic             w_pop;
   logic [2:0]       w_next_occ;
   logic             w_fifo_vld;
   logic [D_BIT:0]   w_fifo_dat;
   logic [1:0]       w_fifo_cnt;

   assign w_we       = iIN_VALID & r_in_rdy & ~r_bank_own;
   assign w_pop      = w_fifo_vld & iOUT_READY;
   // Occupancy next cycle: the in-flight read lands, the head may leave.
   assign w_next_occ = {1'b0, w_fifo_cnt} + {2'b0, r_rd_pend} - {2'b0, w_pop};
   // Issue only if the word it returns next-next cycle is guaranteed a slot.
   assign w_issue    = (r_state == S_UNLOAD) & ~r_rd_all & (w_next_occ < 3'd2);

   assign oIN_READY   = r_in_rdy;
   assign oCORE_START = r_start;
   assign oBANK_OWN   = r_bank_own;
   assign oBUSY       = (r_state != S_IDLE);
   assign oFRAME_DONE = r_done;
   assign oERR        = r_err;
   assign oIO_WE      = w_we;
   assign oIO_WDATA   = w_we ? iIN_DATA : '0;
   // Natural order for load and unload: low two bits pick the bank.
   assign oIO_BANK    = r_k[1:0];
   assign oIO_ADDR    = r_k[K_BIT-1:2];
   assign oOUT_VALID  = w_fifo_vld;
   assign oOUT_DATA   = w_fifo_dat[D_BIT-1:0];
   assign oOUT_LAST   = w_fifo_dat[D_BIT];

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_state        <= S_IDLE;
         r_k            <= '0;
         r_tmo          <= 3'd0;
         r_in_rdy       <= 1'b0;
         r_bank_own     <= 1'b0;
         r_start        <= 1'b0;
         r_err          <= 1'b0;
         r_done         <= 1'b0;
         r_rd_pend      <= 1'b0;
         r_rd_pend_last <= 1'b0;
         r_rd_all       <= 1'b0;
      end else begin
         r_start        <= 1'b0;
         r_done         <= 1'b0;
         r_rd_pend      <= w_issue;
         r_rd_pend_last <= w_issue & (r_k == K_LAST);
         case (r_state)
            S_IDLE: begin
               r_in_rdy <= 1'b1;
               if (w_we) begin
                  r_k     <= r_k + 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_we) begin
                  // k wraps to zero on the last point, ready for unload.
                  r_k <= r_k + 1'b1;
                  if (r_k == K_LAST) begin
                     r_state    <= S_KICK;
                     r_in_rdy   <= 1'b0;
                     r_bank_own <= 1'b1;
                     r_start    <= 1'b1;
                     r_err      <= 1'b0;
                  end
               end
            end
            S_KICK: begin
               r_tmo   <= 3'd1;
               r_state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!iCORE_RDY) begin
                  r_state <= S_WAIT_HI;
               end else if (r_tmo == C_TMO_LAST) begin
                  // Core never acknowledged: flag it and hand the banks back.
                  r_err      <= 1'b1;
                  r_bank_own <= 1'b0;
                  r_in_rdy   <= 1'b1;
                  r_k        <= '0;
                  r_state    <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + 3'd1;
               end
            end
            S_WAIT_HI: begin
               if (iCORE_RDY) begin
                  r_bank_own <= 1'b0;
                  r_rd_all   <= 1'b0;
                  r_state    <= S_UNLOAD;
               end
            end
            S_UNLOAD: begin
               if (w_issue) begin
                  r_k <= r_k + 1'b1;
                  if (r_k == K_LAST) begin
                     r_rd_all <= 1'b1;
                  end
               end
               if (w_pop && w_fifo_dat[D_BIT]) begin
                  r_done   <= 1'b1;
                  r_in_rdy <= 1'b1;
                  r_k      <= '0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   fht_skid_fifo #(
      .W (D_BIT + 1)
   ) u_out_fifo (
      .i_clk    (iCLK),
      .i_rst_n  (iRESET),
      .i_wr_vld (r_rd_pend),
      .i_wr_dat ({r_rd_pend_last, iIO_RDATA}),
      .o_rd_vld (w_fifo_vld),
      .o_rd_dat (w_fifo_dat),
      .i_rd_rdy (iOUT_READY),
      .o_cnt    (w_fifo_cnt)
   );

endmodule
